uart_rx_byte: RTL
=================

Name: uart_rx_byte

Overview:
- Serial receive stage that sits directly upstream of the 7-segment hex byte display driver.
- Recovers 8N1 UART frames from the board's RX pin and holds the last good byte on a stable bus wired to the display's hex_byte input.
- Also provides a one-cycle strobe and a framing-error flag for other consumers and the board LEDs.

Parameters:
- sys_clk_freq, 100000000, system clock frequency in Hz.
- baud_rate, 115200, serial bit rate in bit/s.
- Derived localparam clks_per_bit = sys_clk_freq / baud_rate (integer division). Requirement: clks_per_bit >= 4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle-high.
- rx_byte  output  8  last correctly framed byte, held stable until the next good frame. LSB = first data bit.
- rx_valid  output  1  one-cycle pulse in the same cycle rx_byte updates.
- frame_error  output  1  set on a bad stop bit; cleared when the next good frame completes.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset values (async assert, sync deassert by the integrator):
  - rx_byte = 8'h00, rx_valid = 0, frame_error = 0, busy = 0, state = IDLE.
  - Bit counter = 0, baud counter = 0, shift register = 0.
  - Synchronizer flops = 1 (line idle).
- Input sync: rx passes through a 2-flop synchronizer; rx_s is the second flop. All decisions use rx_s only (2-cycle input latency).
- Baud counter counts 0..clks_per_bit-1. A "tick" is the cycle where the count equals its target; the counter reloads to 0 on each tick.
- States:
  - IDLE: busy=0. If rx_s==0, go to START and clear the baud counter.
  - START: tick at count == clks_per_bit/2 - 1 (mid start bit).
    - If rx_s==1 on the tick: glitch. Return to IDLE; no outputs change.
    - Else: go to DATA, bit index = 0.
  - DATA: tick every clks_per_bit cycles (mid bit).
    - Each tick shifts rx_s into the MSB of the shift register (right shift); after 8 bits the first bit received ends at bit 0.
    - After bit index 7, go to STOP.
  - STOP: on the mid-stop-bit tick:
    - rx_s==1: in the next cycle, rx_byte <= shift register, rx_valid = 1 for exactly one cycle, frame_error <= 0. Go to IDLE.
    - rx_s==0: frame_error <= 1; rx_byte and rx_valid unchanged. Go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from being re-read as continuous start bits.
- Latency: rx_valid asserts 1 cycle after the mid-stop sample. That is ≈ 9.5·clks_per_bit + 3 cycles after the rx falling edge.
- Back-to-back frames: a start edge arriving in the cycle IDLE is re-entered is accepted. No dead time beyond that one cycle.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values immediately. A partially received frame never appears on rx_byte.
- rx_byte never changes except on a good frame, so the display shows a stable value between frames.
- No handshake or backpressure. A consumer that misses rx_valid loses only the strobe; rx_byte still holds the value.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE, START, DATA, STOP, WAIT_HIGH; 3-bit);
  - the clks_per_bit derivation function;
  - frame constants (data_bits = 8, stop_bits = 1).
- One natural sub-module: sync_2ff (1-bit, 2-flop synchronizer with async active-high reset and a parameterised reset value, here 1). It is reused later for the button inputs.
- Top-level integration: rx_byte drives display_hex_byte.hex_byte directly.

Test Plan (sys_clk_freq=1000000, baud_rate=100000, so clks_per_bit=10):
- Send byte 8'hA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> rx_valid pulses once for one cycle; rx_byte = 8'hA5; frame_error = 0; busy falls in the rx_valid cycle.
- Send 8'h3C then 8'hFF back-to-back with no idle gap -> two rx_valid pulses exactly 100 cycles apart; rx_byte = 8'h3C, then 8'hFF.
- Drive a 3-cycle low glitch on idle rx -> no rx_valid; busy returns to 0 within 8 cycles; rx_byte unchanged.
- Send 8'h55 with stop bit = 0, hold rx low 50 cycles, then release, then send 8'h12 ->
  - after the bad frame: frame_error = 1, rx_byte still holds the previous value, no rx_valid;
  - state stays WAIT_HIGH until rx is released;
  - after 8'h12: rx_byte = 8'h12 and frame_error clears in the rx_valid cycle.
- Assert rst during data bit 4 of 8'hC3 -> outputs immediately go to 0 and rx_byte = 8'h00. The rest of the frame is ignored. After rst release, a clean 8'h7E is received correctly.
- Hold rx high for 1000 cycles after reset -> busy, rx_valid and frame_error stay 0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types, frame constants and baud helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int data_bits = 8;
    localparam int stop_bits = 1;

    function automatic int calc_clks_per_bit(input int sys_clk_freq, input int baud_rate);
        return sys_clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer with selectable reset value
module sync_2ff #(
    parameter logic rst_val = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver holding the last good byte for the hex display
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int sys_clk_freq = 100000000,
    parameter int baud_rate    = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int clks_per_bit = calc_clks_per_bit(sys_clk_freq, baud_rate);
    localparam int cnt_w        = $clog2(clks_per_bit);
    localparam logic [cnt_w-1:0] full_tick = cnt_w'(clks_per_bit - 1);
    localparam logic [cnt_w-1:0] half_tick = cnt_w'(clks_per_bit / 2 - 1);
    localparam logic [2:0]       last_bit  = 3'(data_bits - 1);

    rx_state_t        state, state_nxt;
    logic [cnt_w-1:0] baud_cnt, cnt_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [7:0]       byte_nxt;
    logic             valid_nxt, fe_nxt;
    logic             rx_s;

    sync_2ff #(.rst_val(1'b1)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            baud_cnt    <= cnt_nxt;
            bit_idx     <= idx_nxt;
            shift_reg   <= shift_nxt;
            rx_byte     <= byte_nxt;
            rx_valid    <= valid_nxt;
            frame_error <= fe_nxt;
        end
    end

    // The start phase waits half a bit so every later tick lands mid-bit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = baud_cnt + 1'b1;
        idx_nxt   = bit_idx;
        shift_nxt = shift_reg;
        byte_nxt  = rx_byte;
        valid_nxt = 1'b0;
        fe_nxt    = frame_error;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (baud_cnt == half_tick) begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == full_tick) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift_reg[7:1]};
                    if (bit_idx == last_bit) state_nxt = STOP;
                    else                     idx_nxt   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (baud_cnt == full_tick) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        byte_nxt  = shift_reg;
                        valid_nxt = 1'b1;
                        fe_nxt    = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        fe_nxt    = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
